// File: rtl/apb_master.sv
// apb_master: single-channel AMBA APB master; turns a transfer strobe plus
// command/address/data words into SETUP/ACCESS phases and returns read data.
// Ports:
//   Pclk, Presetn       - clock, async active-low reset
//   addr_temp[32:0]     - {dir(1=write), addr[31:0]} request word
//   data_temp[31:0]     - write data for the request
//   transfer            - level request strobe
//   Prdata, Pready      - slave read data / ready
//   Psel, Penable       - APB select / enable (decoded from state)
//   Pwrite, Paddr, Pdata- captured direction, address, write data
//   rdata_temp          - last completed read data
module apb_master (
  input  logic        Pclk,
  input  logic        Presetn,
  input  logic [32:0] addr_temp,
  input  logic [31:0] data_temp,
  input  logic        transfer,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  output logic        Psel,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pdata,
  output logic [31:0] rdata_temp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e      state_q;
  logic        pwrite_q;
  logic [31:0] paddr_q;
  logic [31:0] pdata_q;
  logic [31:0] rdata_q;

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q  <= SETUP;
            paddr_q  <= addr_temp[31:0];
            pwrite_q <= addr_temp[32];
            pdata_q  <= data_temp;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (Pready) begin
            if (!pwrite_q) begin
              rdata_q <= Prdata;
            end
            // Back-to-back: skip IDLE and capture the next request here.
            if (transfer) begin
              state_q  <= SETUP;
              paddr_q  <= addr_temp[31:0];
              pwrite_q <= addr_temp[32];
              pdata_q  <= data_temp;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign Penable    = (state_q == ACCESS);
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pdata      = pdata_q;
  assign rdata_temp = rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_apb_master;

  logic        Pclk;
  logic        Presetn;
  logic [32:0] addr_temp;
  logic [31:0] data_temp;
  logic        transfer;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pdata;
  logic [31:0] rdata_temp;

  int passed = 0;
  int total  = 0;

  apb_master dut (
    .Pclk      (Pclk),
    .Presetn   (Presetn),
    .addr_temp (addr_temp),
    .data_temp (data_temp),
    .transfer  (transfer),
    .Prdata    (Prdata),
    .Pready    (Pready),
    .Psel      (Psel),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pdata     (Pdata),
    .rdata_temp(rdata_temp)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag,
                         input logic sel, input logic en);
    chk({tag, ".Psel"}, {31'd0, Psel}, {31'd0, sel});
    chk({tag, ".Penable"}, {31'd0, Penable}, {31'd0, en});
  endtask

  initial begin
    // Reset with random inputs and transfer asserted
    Presetn   = 1'b0;
    addr_temp = {1'b1, $urandom()};
    data_temp = $urandom();
    Prdata    = $urandom();
    Pready    = 1'b1;
    transfer  = 1'b1;
    repeat (3) tick();
    chk_bus("rst", 1'b0, 1'b0);
    chk("rst.Pwrite", {31'd0, Pwrite}, 32'd0);
    chk("rst.Paddr", Paddr, 32'd0);
    chk("rst.Pdata", Pdata, 32'd0);
    chk("rst.rdata", rdata_temp, 32'd0);

    // Write, transfer high for two cycles
    Presetn   = 1'b1;
    addr_temp = {1'b1, 32'hA000_0000};
    data_temp = 32'hDEAD_BEEF;
    Pready    = 1'b1;
    transfer  = 1'b1;
    tick();
    chk_bus("wr.setup", 1'b1, 1'b0);
    chk("wr.Paddr", Paddr, 32'hA000_0000);
    chk("wr.Pwrite", {31'd0, Pwrite}, 32'd1);
    chk("wr.Pdata", Pdata, 32'hDEAD_BEEF);
    tick();
    chk_bus("wr.access", 1'b1, 1'b1);
    transfer = 1'b0;
    tick();
    chk_bus("wr.idle", 1'b0, 1'b0);
    chk("wr.rdata", rdata_temp, 32'd0);
    chk("wr.Paddr_hold", Paddr, 32'hA000_0000);

    // Read, zero wait states
    addr_temp = {1'b0, 32'hA000_0004};
    Prdata    = 32'h1234_5678;
    transfer  = 1'b1;
    tick();
    transfer = 1'b0;
    chk_bus("rd.setup", 1'b1, 1'b0);
    chk("rd.Pwrite", {31'd0, Pwrite}, 32'd0);
    chk("rd.Paddr", Paddr, 32'hA000_0004);
    tick();
    chk_bus("rd.access", 1'b1, 1'b1);
    chk("rd.rdata_pre", rdata_temp, 32'd0);
    tick();
    chk_bus("rd.idle", 1'b0, 1'b0);
    chk("rd.rdata", rdata_temp, 32'h1234_5678);

    // Read with three wait states
    addr_temp = {1'b0, 32'hA000_0008};
    Prdata    = 32'h1111_1111;
    Pready    = 1'b0;
    transfer  = 1'b1;
    tick();
    transfer  = 1'b0;
    addr_temp = {1'b1, 32'h5555_5555};
    chk_bus("ws.setup", 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_bus("ws.wait", 1'b1, 1'b1);
      chk("ws.Paddr", Paddr, 32'hA000_0008);
      chk("ws.rdata_hold", rdata_temp, 32'h1234_5678);
      tick();
    end
    chk_bus("ws.last", 1'b1, 1'b1);
    chk("ws.Paddr_last", Paddr, 32'hA000_0008);
    Prdata = 32'hCAFE_F00D;
    Pready = 1'b1;
    tick();
    chk_bus("ws.idle", 1'b0, 1'b0);
    chk("ws.rdata", rdata_temp, 32'hCAFE_F00D);

    // Back-to-back write then read
    addr_temp = {1'b1, 32'hA000_0000};
    data_temp = 32'h5555_AAAA;
    Pready    = 1'b1;
    transfer  = 1'b1;
    tick();
    chk_bus("b2b.setup1", 1'b1, 1'b0);
    chk("b2b.Pdata", Pdata, 32'h5555_AAAA);
    addr_temp = {1'b0, 32'hA000_0004};
    Prdata    = 32'h8765_4321;
    tick();
    chk_bus("b2b.access1", 1'b1, 1'b1);
    chk("b2b.Paddr1", Paddr, 32'hA000_0000);
    chk("b2b.Pwrite1", {31'd0, Pwrite}, 32'd1);
    tick();
    transfer = 1'b0;
    chk_bus("b2b.setup2", 1'b1, 1'b0);
    chk("b2b.Paddr2", Paddr, 32'hA000_0004);
    chk("b2b.Pwrite2", {31'd0, Pwrite}, 32'd0);
    chk("b2b.rdata_wr", rdata_temp, 32'hCAFE_F00D);
    tick();
    chk_bus("b2b.access2", 1'b1, 1'b1);
    tick();
    chk_bus("b2b.idle", 1'b0, 1'b0);
    chk("b2b.rdata", rdata_temp, 32'h8765_4321);

    // Reset asserted during ACCESS
    addr_temp = {1'b0, 32'hA000_000C};
    Pready    = 1'b0;
    transfer  = 1'b1;
    tick();
    transfer = 1'b0;
    tick();
    chk_bus("mr.access", 1'b1, 1'b1);
    Prdata = 32'hFFFF_FFFF;
    Pready = 1'b1;
    #2;
    Presetn = 1'b0;
    #1;
    chk_bus("mr.async", 1'b0, 1'b0);
    chk("mr.Paddr", Paddr, 32'd0);
    chk("mr.rdata", rdata_temp, 32'd0);
    tick();
    Presetn = 1'b1;
    tick();
    chk_bus("mr.idle", 1'b0, 1'b0);
    chk("mr.rdata_after", rdata_temp, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
